// File: rtl/ascii_word_matcher.sv
// Byte-stream matcher for the words "Guatemala" and "Quetzal".
// Latency: match/mismatch/index/match_count register one cycle after the deciding byte; expected is combinational.
// Backpressure: none; every byte presented with rx_valid is consumed in its cycle.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   word_sel        00/11 selects "Guatemala", 01/10 selects "Quetzal"
//   rx_valid/data   one ASCII byte per strobe
//   match/mismatch  one-cycle pulses: word completed / partial match broken
//   index           characters of the current word matched so far
//   expected        character expected next for (word_sel, index)
//   match_count     saturating count of completed matches since reset
module ascii_word_matcher #(
    parameter int COUNT_W   = 8,
    parameter bit CASE_FOLD = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         word_sel,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               match,
    output logic               mismatch,
    output logic [3:0]         index,
    output logic [7:0]         expected,
    output logic [COUNT_W-1:0] match_count
);

    // Word tables. Out-of-range indices return the first character so that
    // expected never shows 8'h00 while a stale index meets a shorter word.
    function automatic logic [7:0] word_char(input logic quetzal, input logic [3:0] idx);
        logic [7:0] c;
        c = 8'h47;
        if (quetzal) begin
            case (idx)
                4'd0:    c = 8'h51;
                4'd1:    c = 8'h75;
                4'd2:    c = 8'h65;
                4'd3:    c = 8'h74;
                4'd4:    c = 8'h7A;
                4'd5:    c = 8'h61;
                4'd6:    c = 8'h6C;
                default: c = 8'h51;
            endcase
        end else begin
            case (idx)
                4'd0:    c = 8'h47;
                4'd1:    c = 8'h75;
                4'd2:    c = 8'h61;
                4'd3:    c = 8'h74;
                4'd4:    c = 8'h65;
                4'd5:    c = 8'h6D;
                4'd6:    c = 8'h61;
                4'd7:    c = 8'h6C;
                4'd8:    c = 8'h61;
                default: c = 8'h47;
            endcase
        end
        return c;
    endfunction

    // Lower-case letters fold onto upper case when case folding is enabled;
    // everything else compares exactly.
    function automatic logic [7:0] fold(input logic [7:0] c);
        if (CASE_FOLD && (c >= 8'h61) && (c <= 8'h7A)) begin
            return c & 8'hDF;
        end
        return c;
    endfunction

    logic [1:0]         sel_q;
    logic [3:0]         index_q, index_d;
    logic               match_q, match_d;
    logic               mismatch_q, mismatch_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic       quetzal;
    logic       sel_chg;
    logic [3:0] eff_idx;
    logic [3:0] last_idx;
    logic       hit;
    logic       first_hit;

    // Both encodings of a word share a table; the raw encoding is still
    // compared against sel_q so that any change of word_sel aborts.
    assign quetzal  = word_sel[1] ^ word_sel[0];
    assign sel_chg  = (word_sel != sel_q);
    assign eff_idx  = sel_chg ? 4'd0 : index_q;
    assign last_idx = quetzal ? 4'd6 : 4'd8;

    assign hit       = (fold(rx_data) == fold(word_char(quetzal, eff_idx)));
    assign first_hit = (fold(rx_data) == fold(word_char(quetzal, 4'd0)));

    // index itself is the state: 0 is IDLE, 1..len-1 is PARTIAL. A full
    // match returns straight to IDLE with a pulse rather than a held state.
    always_comb begin
        index_d    = eff_idx;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        count_d    = count_q;
        if (rx_valid) begin
            if (hit) begin
                if (eff_idx == last_idx) begin
                    index_d = 4'd0;
                    match_d = 1'b1;
                    if (count_q != {COUNT_W{1'b1}}) begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end else begin
                    index_d = eff_idx + 4'd1;
                end
            end else begin
                // The first character never recurs inside either word, so
                // restarting at 0 or 1 loses no overlapping match.
                mismatch_d = (eff_idx != 4'd0);
                index_d    = first_hit ? 4'd1 : 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= 2'b00;
            index_q    <= 4'd0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            count_q    <= '0;
        end else begin
            sel_q      <= word_sel;
            index_q    <= index_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            count_q    <= count_d;
        end
    end

    assign match       = match_q;
    assign mismatch    = mismatch_q;
    assign index       = index_q;
    assign expected    = word_char(quetzal, index_q);
    assign match_count = count_q;

endmodule

// File: tb/tb_ascii_word_matcher.sv
// Bench for ascii_word_matcher: exact-case and case-folding instances share stimulus.
// Reference model tracks received bytes and finds the longest word prefix at the tail.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_ascii_word_matcher;

    logic       clk;
    logic       reset;
    logic [1:0] word_sel;
    logic       rx_valid;
    logic [7:0] rx_data;

    logic       match0, mismatch0, match1, mismatch1;
    logic [3:0] index0, index1;
    logic [7:0] expected0, expected1, count0, count1;

    ascii_word_matcher #(.COUNT_W(8), .CASE_FOLD(1'b0)) dut (
        .clk(clk), .reset(reset), .word_sel(word_sel), .rx_valid(rx_valid),
        .rx_data(rx_data), .match(match0), .mismatch(mismatch0), .index(index0),
        .expected(expected0), .match_count(count0)
    );

    ascii_word_matcher #(.COUNT_W(8), .CASE_FOLD(1'b1)) dut_cf (
        .clk(clk), .reset(reset), .word_sel(word_sel), .rx_valid(rx_valid),
        .rx_data(rx_data), .match(match1), .mismatch(mismatch1), .index(index1),
        .expected(expected1), .match_count(count1)
    );

    wire [21:0] obs0 = {match0, mismatch0, index0, expected0, count0};
    wire [21:0] obs1 = {match1, mismatch1, index1, expected1, count1};

    int vec  = 0;
    int errs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    byte unsigned hist [2][9];
    int           hlen [2];
    int           m_idx[2];
    int           m_cnt[2];
    bit           m_mt [2];
    bit           m_mm [2];
    logic [1:0]   prev_sel;
    bit           have_prev;

    function automatic string word_of(input logic [1:0] s);
        return (s == 2'b01 || s == 2'b10) ? "Quetzal" : "Guatemala";
    endfunction

    function automatic byte unsigned up(input int m, input byte unsigned c);
        if (m == 1 && c >= "a" && c <= "z") return c - 8'd32;
        return c;
    endfunction

    function automatic bit tail_is_prefix(input int m, input string w, input int k);
        if (hlen[m] < k) return 1'b0;
        for (int i = 0; i < k; i++)
            if (up(m, hist[m][hlen[m] - k + i]) != up(m, w[i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pref(input int m, input string w);
        for (int k = w.len() - 1; k >= 1; k--)
            if (tail_is_prefix(m, w, k)) return k;
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            hlen[m] = 0; m_idx[m] = 0; m_cnt[m] = 0; m_mt[m] = 0; m_mm[m] = 0;
        end
        have_prev = 0;
    endtask

    task automatic model_step(input bit v, input byte unsigned d, input logic [1:0] s);
        string w;
        int    old_k, new_k;
        w = word_of(s);
        for (int m = 0; m < 2; m++) begin
            if (!have_prev || s != prev_sel) hlen[m] = 0;
            m_mt[m] = 0;
            m_mm[m] = 0;
            if (v) begin
                old_k = pref(m, w);
                if (hlen[m] == 9) begin
                    for (int i = 0; i < 8; i++) hist[m][i] = hist[m][i+1];
                    hlen[m] = 8;
                end
                hist[m][hlen[m]] = d;
                hlen[m]++;
                if (tail_is_prefix(m, w, w.len())) begin
                    m_mt[m] = 1;
                    if (m_cnt[m] < 255) m_cnt[m]++;
                    hlen[m] = 0;
                end else begin
                    new_k   = pref(m, w);
                    m_mm[m] = (old_k > 0) && (new_k != old_k + 1);
                end
            end
            m_idx[m] = pref(m, w);
        end
        prev_sel  = s;
        have_prev = 1;
    endtask

    function automatic logic [21:0] model_vec(input int m);
        string      w;
        logic [7:0] e;
        w = word_of(word_sel);
        e = (m_idx[m] < w.len()) ? w[m_idx[m]] : w[0];
        return {m_mt[m], m_mm[m], 4'(m_idx[m]), e, 8'(m_cnt[m])};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick(input bit v, input byte unsigned d, input logic [1:0] s);
        @(negedge clk);
        rx_valid = v; rx_data = d; word_sel = s;
        @(posedge clk);
        model_step(v, d, s);
        #1;
    endtask

    task automatic reset_on();
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic reset_off(input logic [1:0] s);
        @(negedge clk);
        word_sel = s; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        reset_on();
        vec++;
        if (obs0 !== 22'({1'b0, 1'b0, 4'd0, 8'h47, 8'd0})) begin
            errs++; $display("FAIL reset_state: got %h want %h", obs0, 22'({1'b0, 1'b0, 4'd0, 8'h47, 8'd0}));
        end
        vec++;
        if (obs1 !== 22'({1'b0, 1'b0, 4'd0, 8'h47, 8'd0})) begin
            errs++; $display("FAIL reset_state_cf: got %h want %h", obs1, 22'({1'b0, 1'b0, 4'd0, 8'h47, 8'd0}));
        end
        reset_off(2'b00);
    endtask

    task automatic test_back_to_back();
        string w = "Guatemala";
        reset_on(); reset_off(2'b00);
        for (int i = 0; i < w.len(); i++) begin
            tick(1'b1, w[i], 2'b00);
            vec++;
            if (obs0 !== model_vec(0)) begin
                errs++; $display("FAIL b2b_char%0d: got %h want %h", i, obs0, model_vec(0));
            end
        end
        vec++;
        if ({match0, mismatch0, index0, count0} !== {1'b1, 1'b0, 4'd0, 8'd1}) begin
            errs++; $display("FAIL b2b_done: got %h want %h", {match0, mismatch0, index0, count0}, {1'b1, 1'b0, 4'd0, 8'd1});
        end
        tick(1'b0, 8'h00, 2'b00);
        vec++;
        if (match0 !== 1'b0) begin
            errs++; $display("FAIL b2b_pulse_width: got %b want 0", match0);
        end
    endtask

    task automatic test_gaps();
        string        w = "Quetzal";
        byte unsigned qexp[7] = '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C};
        reset_on(); reset_off(2'b01);
        for (int i = 0; i < 7; i++) begin
            vec++;
            if (expected0 !== qexp[i] || index0 !== 4'(i)) begin
                errs++; $display("FAIL gaps_expected%0d: got %h/%0d want %h/%0d", i, expected0, index0, qexp[i], i);
            end
            tick(1'b1, w[i], 2'b01);
            for (int g = 0; g < 3; g++) begin
                tick(1'b0, 8'hFF, 2'b01);
                vec++;
                if (obs0 !== model_vec(0)) begin
                    errs++; $display("FAIL gaps_hold%0d_%0d: got %h want %h", i, g, obs0, model_vec(0));
                end
            end
        end
        vec++;
        if (count0 !== 8'd1 || index0 !== 4'd0) begin
            errs++; $display("FAIL gaps_count: got %0d/%0d want 1/0", count0, index0);
        end
    endtask

    task automatic test_restart();
        string w = "GuaGuatemala";
        reset_on(); reset_off(2'b00);
        for (int i = 0; i < w.len(); i++) begin
            tick(1'b1, w[i], 2'b00);
            vec++;
            if (obs0 !== model_vec(0)) begin
                errs++; $display("FAIL restart_char%0d: got %h want %h", i, obs0, model_vec(0));
            end
            if (i == 3) begin
                vec++;
                if (mismatch0 !== 1'b1 || index0 !== 4'd1) begin
                    errs++; $display("FAIL restart_mismatch: got %b/%0d want 1/1", mismatch0, index0);
                end
            end
        end
        vec++;
        if (match0 !== 1'b1 || count0 !== 8'd1) begin
            errs++; $display("FAIL restart_match: got %b/%0d want 1/1", match0, count0);
        end
    endtask

    task automatic test_sel_switch();
        string a = "Que";
        string b = "uatemala";
        reset_on(); reset_off(2'b01);
        for (int i = 0; i < a.len(); i++) tick(1'b1, a[i], 2'b01);
        tick(1'b1, 8'h47, 2'b00);
        vec++;
        if (mismatch0 !== 1'b0 || index0 !== 4'd1) begin
            errs++; $display("FAIL switch_abort: got %b/%0d want 0/1", mismatch0, index0);
        end
        for (int i = 0; i < b.len(); i++) begin
            tick(1'b1, b[i], 2'b00);
            vec++;
            if (obs0 !== model_vec(0)) begin
                errs++; $display("FAIL switch_char%0d: got %h want %h", i, obs0, model_vec(0));
            end
        end
        vec++;
        if (match0 !== 1'b1) begin
            errs++; $display("FAIL switch_match: got %b want 1", match0);
        end
    endtask

    task automatic test_saturation();
        string w = "Guatemala";
        reset_on(); reset_off(2'b11);
        for (int n = 0; n < 257; n++) begin
            for (int i = 0; i < w.len(); i++) begin
                tick(1'b1, w[i], 2'b11);
                vec++;
                if (obs0 !== model_vec(0) || obs1 !== model_vec(1)) begin
                    errs++; $display("FAIL sat_n%0d_c%0d: got %h/%h want %h/%h", n, i, obs0, obs1, model_vec(0), model_vec(1));
                end
            end
        end
        vec++;
        if (count0 !== 8'hFF || count1 !== 8'hFF) begin
            errs++; $display("FAIL sat_held: got %h/%h want ff/ff", count0, count1);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, w[i], 2'b11);
        reset_on();
        vec++;
        if (index0 !== 4'd0 || count0 !== 8'd0 || index1 !== 4'd0 || count1 !== 8'd0) begin
            errs++; $display("FAIL sat_async_reset: got %0d/%0d want 0/0", index0, count0);
        end
        reset_off(2'b00);
    endtask

    task automatic test_case_fold();
        string lo = "quetZAL";
        string hi = "QuetZAL";
        reset_on(); reset_off(2'b10);
        for (int i = 0; i < lo.len(); i++) begin
            tick(1'b1, lo[i], 2'b10);
            vec++;
            if (obs0 !== model_vec(0) || obs1 !== model_vec(1)) begin
                errs++; $display("FAIL fold_lo%0d: got %h/%h want %h/%h", i, obs0, obs1, model_vec(0), model_vec(1));
            end
        end
        vec++;
        if (match1 !== 1'b1 || match0 !== 1'b0) begin
            errs++; $display("FAIL fold_lo_match: got %b/%b want 1/0", match1, match0);
        end
        for (int i = 0; i < hi.len(); i++) begin
            tick(1'b1, hi[i], 2'b10);
            if (i == 4) begin
                vec++;
                if (mismatch0 !== 1'b1 || mismatch1 !== 1'b0) begin
                    errs++; $display("FAIL fold_exact_mismatch: got %b/%b want 1/0", mismatch0, mismatch1);
                end
            end
        end
        vec++;
        if (match1 !== 1'b1 || count1 !== 8'd2 || count0 !== 8'd0) begin
            errs++; $display("FAIL fold_hi_match: got %b/%0d/%0d want 1/2/0", match1, count1, count0);
        end
    endtask

    task automatic test_random();
        string        pool = "GuatemlQzGUATQgqx!";
        string        w;
        logic [1:0]   s;
        byte unsigned d;
        bit           v;
        reset_on(); reset_off(2'b00);
        s = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) s = 2'($urandom_range(0, 3));
            v = ($urandom_range(0, 9) < 7);
            w = word_of(s);
            if ($urandom_range(0, 9) < 6 && s == prev_sel)
                d = (m_idx[0] < w.len()) ? w[m_idx[0]] : w[0];
            else
                d = pool[$urandom_range(0, pool.len() - 1)];
            if ($urandom_range(0, 3) == 0 && d >= "A" && d <= "Z") d = d + 8'd32;
            tick(v, d, s);
            vec++;
            if (obs0 !== model_vec(0) || obs1 !== model_vec(1)) begin
                errs++; $display("FAIL rand%0d: got %h/%h want %h/%h", n, obs0, obs1, model_vec(0), model_vec(1));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        word_sel = 2'b00;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        prev_sel = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_restart();
        test_sel_switch();
        test_saturation();
        test_case_fold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
